// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential fixed-point divider.
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fp_div_state_e;

  function automatic int FP_DIV_ITERS(input int width, input int frac);
    return width + frac;
  endfunction

  // All-ones pattern of the requested width, e.g. the largest representable quotient.
  function automatic logic [63:0] fp_div_all_ones(input int width);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module fp_div_step
  import fp_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] div_ext;

  assign shifted = {rem_i, bit_i};
  assign div_ext = {2'b00, div_i};
  assign q_o     = (shifted >= div_ext);
  assign rem_o   = q_o ? (WIDTH+1)'(shifted - div_ext) : (WIDTH+1)'(shifted);

endmodule

// File: rtl/fp_div_seq.sv
// Sequential unsigned fixed-point restoring divider, one quotient bit per cycle.
// Define FP_DIV_SAT_EN to saturate the quotient to all ones on overflow.
//
// state | meaning
// IDLE  | waiting for go
// RUN   | iterating, one quotient bit per edge
// DONE  | results registered, done high for this cycle
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             go_i,
  input  logic [WIDTH-1:0] left_i,
  input  logic [WIDTH-1:0] right_i,
  output logic [WIDTH-1:0] out_quotient_o,
  output logic [WIDTH-1:0] out_remainder_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic             div_by_zero_o
);

  localparam int N  = FP_DIV_ITERS(WIDTH, FRAC_WIDTH);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [63:0]   SAT_FULL = fp_div_all_ones(INT_WIDTH + FRAC_WIDTH);

  fp_div_state_e    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [N-2:0]     quo_q, quo_d;   // bits shifted so far; the last bit comes straight from the step
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] oq_q, oq_d;
  logic [WIDTH-1:0] or_q, or_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [N-1:0]     q_full;
  logic             q_ovf;

  fp_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[N-1]),
    .div_i (div_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign q_full = {quo_q, step_q};
  assign q_ovf  = |q_full[N-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    oq_d    = oq_q;
    or_d    = or_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (go_i) begin
          if (right_i != '0) begin
            state_d = RUN;
            div_d   = right_i;
            dvd_d   = {left_i, {FRAC_WIDTH{1'b0}}};
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            oq_d    = SAT_FULL[WIDTH-1:0];
            or_d    = left_i;
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
          end
        end
      end
      RUN: begin
        dvd_d = {dvd_q[N-2:0], 1'b0};
        rem_d = step_rem;
        quo_d = q_full[N-2:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef FP_DIV_SAT_EN
          oq_d    = q_ovf ? SAT_FULL[WIDTH-1:0] : q_full[WIDTH-1:0];
`else
          oq_d    = q_full[WIDTH-1:0];
`endif
          or_d    = step_rem[WIDTH-1:0];
          ovf_d   = q_ovf;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      oq_q    <= '0;
      or_q    <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign done_o          = (state_q == DONE);
  assign out_quotient_o  = oq_q;
  assign out_remainder_o = or_q;
  assign overflow_o      = ovf_q;
  assign div_by_zero_o   = dbz_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq (Q16.16, 48 iterations).
module tb_fp_div_seq;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic [31:0] left;
  logic [31:0] right;
  logic [31:0] out_q;
  logic [31:0] out_r;
  logic        done;
  logic        ovf;
  logic        dbz;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int first_done;
  int done_cnt;
  logic [31:0] exp_ovf_q;

  fp_div_seq dut (
    .clk_i           (clk),
    .reset_ni        (rst_n),
    .go_i            (go),
    .left_i          (left),
    .right_i         (right),
    .out_quotient_o  (out_q),
    .out_remainder_o (out_r),
    .done_o          (done),
    .overflow_o      (ovf),
    .div_by_zero_o   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: go is sampled at the following posedge (E0).
  // Operands are scrambled afterwards to show they were latched.
  task automatic issue(input logic [31:0] l, input logic [31:0] r);
    left  = l;
    right = r;
    go    = 1'b1;
    @(negedge clk);
    go    = 1'b0;
    left  = 32'hDEAD_BEEF;
    right = 32'h0;
  endtask

  // Returns k such that done is first seen after edge E_k (bounded).
  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    go    = 1'b0;
    left  = '0;
    right = '0;
    rst_n = 1'b0;
`ifdef FP_DIV_SAT_EN
    exp_ovf_q = 32'hFFFF_FFFF;
`else
    exp_ovf_q = 32'h0000_0000;
`endif
    repeat (3) @(negedge clk);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q", out_q, 32'd0);
    chk("rst_r", out_r, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_dbz", {31'b0, dbz}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 / 2.0
    issue(32'h0001_0000, 32'h0002_0000);
    wait_done(lat);
    chk("half_lat", lat, 32'd48);
    chk("half_q", out_q, 32'h0000_8000);
    chk("half_r", out_r, 32'h0);
    chk("half_ovf", {31'b0, ovf}, 32'd0);
    chk("half_dbz", {31'b0, dbz}, 32'd0);
    @(negedge clk);
    chk("half_pulse", {31'b0, done}, 32'd0);

    // 1.0 / 3.0, then back-to-back 3.0 / 0.5 issued in the DONE cycle
    issue(32'h0001_0000, 32'h0003_0000);
    wait_done(lat);
    chk("third_lat", lat, 32'd48);
    chk("third_q", out_q, 32'h0000_5555);
    chk("third_r", out_r, 32'h0001_0000);
    issue(32'h0003_0000, 32'h0000_8000);
    chk("b2b_nodone", {31'b0, done}, 32'd0);
    chk("b2b_hold", out_q, 32'h0000_5555);
    wait_done(lat);
    chk("b2b_lat", lat, 32'd48);
    chk("b2b_q", out_q, 32'h0006_0000);
    chk("b2b_r", out_r, 32'h0);

    // raw 7 / 3 (fraction LSBs): 0x70000/3 = 0x25555 rem 1
    @(negedge clk);
    issue(32'h0000_0007, 32'h0000_0003);
    wait_done(lat);
    chk("raw_q", out_q, 32'h0002_5555);
    chk("raw_r", out_r, 32'h0000_0001);

    // overflow
    @(negedge clk);
    issue(32'h7FFF_0000, 32'h0000_0001);
    wait_done(lat);
    chk("ovf_lat", lat, 32'd48);
    chk("ovf_flag", {31'b0, ovf}, 32'd1);
    chk("ovf_q", out_q, exp_ovf_q);
    chk("ovf_r", out_r, 32'h0);

    // divide by zero
    @(negedge clk);
    issue(32'h0005_0000, 32'h0000_0000);
    wait_done(lat);
    chk("dbz_lat", lat, 32'd0);
    chk("dbz_q", out_q, 32'hFFFF_FFFF);
    chk("dbz_r", out_r, 32'h0005_0000);
    chk("dbz_flag", {31'b0, dbz}, 32'd1);
    chk("dbz_ovf", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    chk("dbz_pulse", {31'b0, done}, 32'd0);

    // go during RUN is ignored
    issue(32'h0001_0000, 32'h0002_0000);
    done_cnt   = 0;
    first_done = -1;
    for (int k = 0; k < 70; k++) begin
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (k == 20) begin
        go    = 1'b1;
        left  = 32'h0005_0000;
        right = 32'h0001_0000;
      end else if (k == 21) begin
        go = 1'b0;
      end
      @(negedge clk);
    end
    chk("ign_first", first_done, 32'd48);
    chk("ign_count", done_cnt, 32'd1);
    chk("ign_q", out_q, 32'h0000_8000);
    chk("ign_dbz", {31'b0, dbz}, 32'd0);

    // reset mid-run
    issue(32'h0001_0000, 32'h0003_0000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", out_q, 32'd0);
    chk("mid_rst_r", out_r, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("mid_rst_nodone", done_cnt, 32'd0);
    issue(32'h0001_0000, 32'h0002_0000);
    wait_done(lat);
    chk("post_rst_lat", lat, 32'd48);
    chk("post_rst_q", out_q, 32'h0000_8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
